// File: rtl/rx_frame_buffer_ctrl.sv
// Ping-pong frame buffer sequencer: streams RX payload bytes into a two-slot SRAM,
// commits frames on the MAC end-of-frame pulse and hands them to the CPU side.
module rx_frame_buffer_ctrl #(
  parameter int OCT     = 8,
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = 1500,
  parameter int EOF_TMO = 8
) (
  input  logic              RX_CLK,
  input  logic              rst_n,
  input  logic              rx_payload_ipv4,
  input  logic [OCT-1:0]    rx_payload,
  input  logic              rx_ethernet_irq,
  output logic              buf_we,
  output logic [ADDR_W:0]   buf_addr,
  output logic [OCT-1:0]    buf_wdata,
  output logic              frame_valid,
  output logic              frame_slot,
  output logic [ADDR_W-1:0] frame_len,
  input  logic              frame_ack,
  output logic              frame_irq,
  output logic [15:0]       drop_cnt
);

  localparam int TMO_W = (EOF_TMO > 2) ? $clog2(EOF_TMO) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  logic [1:0]                  state, state_nxt;
  logic                        wr_slot, rd_slot, rd_nxt;
  logic [1:0]                  slot_full, full_nxt;
  logic [ADDR_W-1:0]           len, len_nxt;
  logic [1:0][ADDR_W-1:0]      len_q, lenq_nxt;
  logic [TMO_W-1:0]            tmo, tmo_nxt;
  logic                        we_nxt;
  logic [ADDR_W:0]             addr_nxt;
  logic [OCT-1:0]              wdata_nxt;
  logic                        commit, drop;

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    tmo_nxt   = tmo;
    we_nxt    = 1'b0;
    addr_nxt  = buf_addr;
    wdata_nxt = buf_wdata;
    commit    = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_payload_ipv4) begin
          if (!slot_full[wr_slot]) begin
            we_nxt    = 1'b1;
            addr_nxt  = {wr_slot, {ADDR_W{1'b0}}};
            wdata_nxt = rx_payload;
            len_nxt   = ADDR_W'(1);
            state_nxt = S_WRITE;
          end else begin
            drop      = 1'b1;
            state_nxt = S_DROP;
          end
        end
      end
      S_WRITE: begin
        if (rx_payload_ipv4) begin
          if (len < ADDR_W'(MAX_LEN)) begin
            we_nxt    = 1'b1;
            addr_nxt  = {wr_slot, len};
            wdata_nxt = rx_payload;
            len_nxt   = len + ADDR_W'(1);
          end else begin
            drop      = 1'b1;
            state_nxt = S_DROP;
          end
        end else begin
          tmo_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // The end-of-frame pulse wins even on the last timeout cycle.
        if (rx_ethernet_irq) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end else if (rx_payload_ipv4) begin
          drop      = 1'b1;
          state_nxt = S_DROP;
        end else if (tmo == TMO_W'(EOF_TMO - 1)) begin
          drop      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmo_nxt = tmo + TMO_W'(1);
        end
      end
      S_DROP: begin
        if (!rx_payload_ipv4) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Commit and ack always target different slots, so both can apply in one cycle.
  always_comb begin
    full_nxt = slot_full;
    rd_nxt   = rd_slot;
    lenq_nxt = len_q;
    if (commit) begin
      full_nxt[wr_slot] = 1'b1;
      lenq_nxt[wr_slot] = len;
    end
    if (frame_ack && frame_valid) begin
      full_nxt[rd_slot] = 1'b0;
      rd_nxt            = ~rd_slot;
    end
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_slot     <= 1'b0;
      rd_slot     <= 1'b0;
      slot_full   <= '0;
      len         <= '0;
      len_q       <= '0;
      tmo         <= '0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      frame_valid <= 1'b0;
      frame_slot  <= 1'b0;
      frame_len   <= '0;
      frame_irq   <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      len         <= len_nxt;
      tmo         <= tmo_nxt;
      buf_we      <= we_nxt;
      buf_addr    <= addr_nxt;
      buf_wdata   <= wdata_nxt;
      slot_full   <= full_nxt;
      len_q       <= lenq_nxt;
      rd_slot     <= rd_nxt;
      if (commit) wr_slot <= ~wr_slot;
      frame_irq   <= commit;
      frame_valid <= full_nxt[rd_nxt];
      frame_slot  <= rd_nxt;
      frame_len   <= lenq_nxt[rd_nxt];
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
